// File: rtl/tile_loop_scheduler.sv
// Tiled-matmul loop sequencer: walks k (innermost), x, y tiles; handshakes DMA, MAC pass, writeback.
// Outputs registered (1-cycle response to each done); waits indefinitely on dones; TILE_PERF_CNT_EN adds busy_cycles.
`timescale 1ns/1ps
module tile_loop_scheduler #(
   parameter int ADDR_WIDTH = 16,
   parameter int TILE_SIZE  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] cfg_matrix_size,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic [ADDR_WIDTH-1:0] tile_x,
   output logic [ADDR_WIDTH-1:0] tile_y,
   output logic [ADDR_WIDTH-1:0] inner_k,
   output logic                  dma_start,
   input  logic                  dma_a_done,
   input  logic                  dma_b_done,
   output logic                  mac_start,
   output logic                  mac_first,
   output logic                  mac_last,
   input  logic                  mac_done,
   output logic                  wb_start,
   input  logic                  wb_done
`ifdef TILE_PERF_CNT_EN
   ,
   output logic [31:0]           busy_cycles
`endif
);

   localparam logic [ADDR_WIDTH-1:0] TSTEP = ADDR_WIDTH'(TILE_SIZE);
   localparam logic [ADDR_WIDTH-1:0] TMASK = ADDR_WIDTH'(TILE_SIZE - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_WB} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] n_lat;
   logic                  a_seen;
   logic                  b_seen;
   logic [ADDR_WIDTH-1:0] last_origin;
   logic                  a_now;
   logic                  b_now;
   logic                  k_last;
   logic                  x_last;
   logic                  y_last;
   logic                  cfg_ok;
   logic                  start_ok;

   // Last-tile tests compare against N-T so an N close to 2^ADDR_WIDTH cannot overflow.
   assign last_origin = n_lat - TSTEP;
   assign k_last      = (inner_k == last_origin);
   assign x_last      = (tile_x == last_origin);
   assign y_last      = (tile_y == last_origin);
   assign a_now       = a_seen | dma_a_done;
   assign b_now       = b_seen | dma_b_done;
   assign cfg_ok      = (cfg_matrix_size != '0) && ((cfg_matrix_size & TMASK) == '0);
   assign start_ok    = (state == S_IDLE) && start && !abort && cfg_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         n_lat     <= '0;
         a_seen    <= 1'b0;
         b_seen    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         tile_x    <= '0;
         tile_y    <= '0;
         inner_k   <= '0;
         dma_start <= 1'b0;
         mac_start <= 1'b0;
         mac_first <= 1'b0;
         mac_last  <= 1'b0;
         wb_start  <= 1'b0;
      end else begin
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         dma_start <= 1'b0;
         mac_start <= 1'b0;
         mac_first <= 1'b0;
         mac_last  <= 1'b0;
         wb_start  <= 1'b0;
         if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            a_seen  <= 1'b0;
            b_seen  <= 1'b0;
            tile_x  <= '0;
            tile_y  <= '0;
            inner_k <= '0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     if (!cfg_ok) begin
                        cfg_err <= 1'b1;
                     end else begin
                        n_lat     <= cfg_matrix_size;
                        tile_x    <= '0;
                        tile_y    <= '0;
                        inner_k   <= '0;
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        dma_start <= 1'b1;
                     end
                  end
               end
               S_LOAD: begin
                  // Dones coincident with the dma_start pulse belong to no request yet.
                  if (!dma_start) begin
                     if (a_now && b_now) begin
                        a_seen    <= 1'b0;
                        b_seen    <= 1'b0;
                        state     <= S_COMPUTE;
                        mac_start <= 1'b1;
                        mac_first <= (inner_k == '0);
                        mac_last  <= k_last;
                     end else begin
                        a_seen <= a_now;
                        b_seen <= b_now;
                     end
                  end
               end
               S_COMPUTE: begin
                  if (mac_done) begin
                     if (k_last) begin
                        state    <= S_WB;
                        wb_start <= 1'b1;
                     end else begin
                        inner_k   <= inner_k + TSTEP;
                        state     <= S_LOAD;
                        dma_start <= 1'b1;
                     end
                  end
               end
               S_WB: begin
                  if (wb_done) begin
                     if (x_last && y_last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        inner_k <= '0;
                        if (x_last) begin
                           tile_x <= '0;
                           tile_y <= tile_y + TSTEP;
                        end else begin
                           tile_x <= tile_x + TSTEP;
                        end
                        state     <= S_LOAD;
                        dma_start <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

`ifdef TILE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_cycles <= '0;
      end else if (start_ok) begin
         busy_cycles <= '0;
      end else if (busy && (busy_cycles != 32'hFFFF_FFFF)) begin
         busy_cycles <= busy_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tile_loop_scheduler.sv
// Directed bench for tile_loop_scheduler: per-cycle vector table plus multi-cycle run sequences.
`timescale 1ns/1ps
module tb_tile_loop_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] cfg = 16'd0;
   logic        busy, done, cfg_err, dma_start, mac_start, mac_first, mac_last, wb_start;
   logic [15:0] tile_x, tile_y, inner_k;
   logic        dma_a_done, dma_b_done, mac_done, wb_done;
   logic        auto_a = 1'b0, auto_b = 1'b0, auto_m = 1'b0, auto_w = 1'b0;
   logic        tbl_a = 1'b0, tbl_b = 1'b0, tbl_m = 1'b0, tbl_w = 1'b0;
   logic        stray_m = 1'b0, stray_w = 1'b0;
`ifdef TILE_PERF_CNT_EN
   logic [31:0] busy_cycles;
`endif

   assign dma_a_done = auto_a | tbl_a;
   assign dma_b_done = auto_b | tbl_b;
   assign mac_done   = auto_m | tbl_m | stray_m;
   assign wb_done    = auto_w | tbl_w | stray_w;

   tile_loop_scheduler #(.ADDR_WIDTH(16), .TILE_SIZE(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_matrix_size(cfg),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .tile_x(tile_x), .tile_y(tile_y), .inner_k(inner_k),
      .dma_start(dma_start), .dma_a_done(dma_a_done), .dma_b_done(dma_b_done),
      .mac_start(mac_start), .mac_first(mac_first), .mac_last(mac_last), .mac_done(mac_done),
      .wb_start(wb_start), .wb_done(wb_done)
`ifdef TILE_PERF_CNT_EN
      , .busy_cycles(busy_cycles)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit auto_en = 1'b0;
   int dly_a = 2, dly_b = 2, dly_m = 2, dly_w = 2;

   // Automatic responder: answers each request after dly_* cycles (driven at +1, read by main at +2).
   initial begin
      int ca, cb, cm, cw;
      ca = 0; cb = 0; cm = 0; cw = 0;
      forever begin
         @(posedge clk);
         #1;
         auto_a = 1'b0; auto_b = 1'b0; auto_m = 1'b0; auto_w = 1'b0;
         if (ca > 0) begin ca--; if (ca == 0) auto_a = 1'b1; end
         if (cb > 0) begin cb--; if (cb == 0) auto_b = 1'b1; end
         if (cm > 0) begin cm--; if (cm == 0) auto_m = 1'b1; end
         if (cw > 0) begin cw--; if (cw == 0) auto_w = 1'b1; end
         if (auto_en && dma_start) begin ca = dly_a; cb = dly_b; end
         if (auto_en && mac_start) cm = dly_m;
         if (auto_en && wb_start)  cw = dly_w;
         if (rst) begin ca = 0; cb = 0; cm = 0; cw = 0; end
      end
   end

   typedef struct {
      logic st, ab; logic [15:0] n; logic a, b, md, wd;
      logic [5:0] e_out;  // {busy, cfg_err, dma_start, mac_start, wb_start, done}
      logic [1:0] e_fl;   // {mac_first, mac_last}, checked only when mac_start expected
   } vec_t;
   vec_t vq[$];

   typedef struct packed { logic [15:0] k, x, y; logic first, last; } step_t;
   step_t seq[$];
   int n_dma, n_wb, n_done, wbd_cyc, done_cyc, start_cyc, a_cyc, mac_cyc;

   task automatic tick();
      @(posedge clk);
      #2;
      cyc++;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, ab, input logic [15:0] n, input logic a, b, md, wd,
                      input logic [5:0] e_out, input logic [1:0] e_fl);
      vec_t v;
      v.st = st; v.ab = ab; v.n = n; v.a = a; v.b = b; v.md = md; v.wd = wd;
      v.e_out = e_out; v.e_fl = e_fl;
      vq.push_back(v);
   endtask

   task automatic run_job(input logic [15:0] n, input bit stray);
      n_dma = 0; n_wb = 0; n_done = 0; wbd_cyc = -100; done_cyc = -1; a_cyc = -100; mac_cyc = -1;
      seq.delete();
      cfg = n; start = 1'b1; start_cyc = cyc;
      tick();
      for (int i = 0; i < 3000; i++) begin
         start = 1'b0; stray_m = 1'b0; stray_w = 1'b0;
         if (dma_start) n_dma++;
         if (wb_start) n_wb++;
         if (dma_a_done) a_cyc = cyc;
         if (wb_done) wbd_cyc = cyc;
         if (mac_start) begin
            seq.push_back('{k: inner_k, x: tile_x, y: tile_y, first: mac_first, last: mac_last});
            mac_cyc = cyc;
         end
         if (done) begin n_done++; done_cyc = cyc; break; end
         if (stray && dma_start) begin stray_m = 1'b1; stray_w = 1'b1; start = 1'b1; cfg = 16'd16; end
         tick();
      end
      start = 1'b0; stray_m = 1'b0; stray_w = 1'b0;
      check("run_done_seen", 64'(n_done), 64'd1);
   endtask

   task automatic check_seq(input string tag, input int n);
      int idx, t;
      step_t e;
      idx = 0;
      t = n / 16;
      check({tag, "_mac_cnt"}, 64'(seq.size()), 64'(t * t * t));
      check({tag, "_dma_cnt"}, 64'(n_dma), 64'(t * t * t));
      check({tag, "_wb_cnt"}, 64'(n_wb), 64'(t * t));
      for (int y = 0; y < n; y += 16)
         for (int x = 0; x < n; x += 16)
            for (int k = 0; k < n; k += 16) begin
               e.k = 16'(k); e.x = 16'(x); e.y = 16'(y);
               e.first = (k == 0); e.last = (k == n - 16);
               if (idx < seq.size()) check($sformatf("%s_step%0d", tag, idx), seq[idx], e);
               idx++;
            end
   endtask

   task automatic wait_mac(input int nth);
      int seen;
      seen = 0;
      for (int i = 0; i < 500 && seen < nth; i++) begin
         tick();
         if (mac_start) seen++;
      end
      check("wait_mac_start", 64'(seen), 64'(nth));
   endtask

   task automatic wait_dma(input int nth);
      int seen;
      seen = 0;
      for (int i = 0; i < 500 && seen < nth; i++) begin
         if (dma_start) seen++;
         if (seen < nth) tick();
      end
      check("wait_dma_start", 64'(seen), 64'(nth));
   endtask

   initial begin
      int quiet_done;
`ifdef TILE_PERF_CNT_EN
      logic [31:0] held;
`endif
      repeat (3) @(posedge clk);
      #2;
      check("reset_out", {busy, done, cfg_err, dma_start, mac_start, mac_first, mac_last, wb_start}, 64'd0);
      check("reset_coord", {tile_x, tile_y, inner_k}, 64'd0);
      rst = 1'b0;

      //   st ab n      a  b  md wd   busy cerr dma mac wb done   first/last
      add(1, 0, 16'd24, 0, 0, 0, 0, 6'b010000, 2'b00);
      add(0, 0, 16'd0,  0, 0, 0, 0, 6'b000000, 2'b00);
      add(1, 0, 16'd0,  0, 0, 0, 0, 6'b010000, 2'b00);
      add(1, 0, 16'd40, 0, 0, 0, 0, 6'b010000, 2'b00);
      add(1, 0, 16'd16, 0, 0, 0, 0, 6'b101000, 2'b00);
      add(0, 0, 16'd16, 1, 1, 0, 0, 6'b100000, 2'b00);  // dones in the dma_start cycle are ignored
      add(0, 0, 16'd16, 0, 0, 1, 1, 6'b100000, 2'b00);  // stray mac/wb dones in LOAD
      add(0, 0, 16'd16, 0, 1, 0, 0, 6'b100000, 2'b00);
      add(1, 0, 16'd32, 0, 0, 0, 0, 6'b100000, 2'b00);  // start while busy
      add(0, 0, 16'd16, 0, 0, 0, 0, 6'b100000, 2'b00);
      add(0, 0, 16'd16, 1, 0, 0, 0, 6'b100100, 2'b11);  // a arrives 3 cycles after b
      add(0, 0, 16'd16, 0, 0, 0, 0, 6'b100000, 2'b00);
      add(0, 0, 16'd16, 0, 0, 1, 0, 6'b100010, 2'b00);
      add(0, 0, 16'd16, 1, 0, 0, 0, 6'b100000, 2'b00);
      add(0, 0, 16'd16, 0, 0, 0, 1, 6'b000001, 2'b00);
      add(0, 0, 16'd16, 0, 0, 0, 0, 6'b000000, 2'b00);
      add(1, 1, 16'd16, 0, 0, 0, 0, 6'b000000, 2'b00);  // abort beats start
      add(1, 0, 16'd16, 0, 0, 0, 0, 6'b101000, 2'b00);
      add(0, 0, 16'd16, 0, 0, 0, 0, 6'b100000, 2'b00);
      add(0, 0, 16'd16, 1, 1, 0, 0, 6'b100100, 2'b11);  // both dones together
      add(0, 1, 16'd16, 0, 0, 0, 0, 6'b000000, 2'b00);  // abort in COMPUTE
      add(0, 0, 16'd16, 0, 0, 1, 0, 6'b000000, 2'b00);

      for (int i = 0; i < vq.size(); i++) begin
         start = vq[i].st; abort = vq[i].ab; cfg = vq[i].n;
         tbl_a = vq[i].a; tbl_b = vq[i].b; tbl_m = vq[i].md; tbl_w = vq[i].wd;
         tick();
         check($sformatf("row%0d", i), {busy, cfg_err, dma_start, mac_start, wb_start, done}, vq[i].e_out);
         if (vq[i].e_out[2]) check($sformatf("row%0d_first_last", i), {mac_first, mac_last}, vq[i].e_fl);
      end
      start = 1'b0; abort = 1'b0; tbl_a = 1'b0; tbl_b = 1'b0; tbl_m = 1'b0; tbl_w = 1'b0;
      tick();

      auto_en = 1'b1;
      run_job(16'd32, 1'b0);
      check_seq("n32", 32);
      check("n32_done_after_wb", 64'(done_cyc - wbd_cyc), 64'd1);
      check("n32_end_state", {busy, tile_x, tile_y, inner_k}, {1'b0, 16'd16, 16'd16, 16'd16});
      tick();
      check("n32_done_pulse_width", done, 1'b0);

      run_job(16'd32, 1'b1);
      check_seq("stray", 32);

      dly_b = 1; dly_a = 4;
      run_job(16'd16, 1'b0);
      check("b_before_a_mac_lat", 64'(mac_cyc - a_cyc), 64'd1);
      dly_b = 2; dly_a = 2;
      run_job(16'd16, 1'b0);
      check("same_cycle_mac_lat", 64'(mac_cyc - a_cyc), 64'd1);
      check("n16_start_to_done", 64'(done_cyc - start_cyc), 64'd10);
`ifdef TILE_PERF_CNT_EN
      check("n16_busy_cycles", busy_cycles, 32'd9);
`endif

      cfg = 16'd32; start = 1'b1;
      tick();
      start = 1'b0;
      wait_mac(2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_state", {busy, mac_start, dma_start, wb_start, done, tile_x, tile_y, inner_k}, 64'd0);
`ifdef TILE_PERF_CNT_EN
      held = busy_cycles;
`endif
      quiet_done = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || busy) quiet_done++;
      end
      check("abort_no_done", 64'(quiet_done), 64'd0);
`ifdef TILE_PERF_CNT_EN
      check("abort_busy_cycles_held", busy_cycles, held);
`endif
      run_job(16'd16, 1'b0);
      check_seq("after_abort", 16);

      cfg = 16'd32; start = 1'b1;
      tick();
      start = 1'b0;
      wait_dma(1);
      tick();
      wait_dma(1);
      check("pre_rst_load", {busy, dma_start, inner_k}, {1'b1, 1'b1, 16'd16});
      #3;
      rst = 1'b1;
      #1;
      check("async_rst", {busy, dma_start, mac_start, tile_x, tile_y, inner_k}, 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_idle", {busy, done, dma_start}, 64'd0);
      run_job(16'd16, 1'b0);
      check_seq("after_rst", 16);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
